// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared op, state and constant definitions for muldiv_hilo_unit
package muldiv_pkg;
  typedef enum logic [1:0] {OP_MULT = 2'b00, OP_MULTU = 2'b01, OP_DIV = 2'b10, OP_DIVU = 2'b11} op_e;
  typedef enum logic [1:0] {IDLE, RUN, FIXUP, DONE} state_e;
  localparam int MAX_W = 64;
  localparam logic [MAX_W-1:0] DIV0_QUOTIENT = '1;
endpackage

// File: rtl/muldiv_hilo_unit_step.sv
// muldiv_step: one unsigned shift-add multiply or restoring shift-subtract divide iteration
module muldiv_step #(
  parameter int W = 32
) (
  input  logic           is_div_i,
  input  logic [2*W-1:0] acc_i,
  input  logic [W-1:0]   opnd_i,
  output logic [2*W-1:0] acc_o
);
  logic [W:0] sum, shifted, trial;
  assign sum = {1'b0, acc_i[2*W-1:W]} + (acc_i[0] ? {1'b0, opnd_i} : {(W+1){1'b0}});
  assign shifted = {acc_i[2*W-1:W], acc_i[W-1]};
  assign trial = shifted - {1'b0, opnd_i};
  assign acc_o = is_div_i ? {trial[W] ? shifted[W-1:0] : trial[W-1:0], acc_i[W-2:0], ~trial[W]}
                          : {sum, acc_i[W-1:1]};
endmodule

// File: rtl/muldiv_hilo_unit.sv
// muldiv_hilo_unit: iterative MULT/MULTU/DIV/DIVU engine driving HI/LO; MULDIV_EARLY_ZERO_EN enables the zero-operand shortcut
module muldiv_hilo_unit
  import muldiv_pkg::*;
#(
  parameter int WORD_SIZE = 32,
  parameter int CNT_W     = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic [WORD_SIZE-1:0] src_a,
  input  logic [WORD_SIZE-1:0] src_b,
  input  logic                 flush,
  output logic                 busy,
  output logic [WORD_SIZE-1:0] hi_out,
  output logic [WORD_SIZE-1:0] lo_out,
  output logic                 hilo_write_en
);
  localparam int W = WORD_SIZE;
  state_e         state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2*W-1:0] acc_q, step_acc, res;
  logic [W-1:0]   opnd_q, a_q, hi_q, lo_q, mag_a, mag_b, quo, rem;
  logic           div_q, neg_q, rneg_q, zero_q, is_div, sgn, early, div0;
  assign is_div = op inside {OP_DIV, OP_DIVU};
  assign sgn = op inside {OP_MULT, OP_DIV};
  assign mag_a = (sgn && src_a[W-1]) ? -src_a : src_a;
  assign mag_b = (sgn && src_b[W-1]) ? -src_b : src_b;
`ifdef MULDIV_EARLY_ZERO_EN
  assign early = (src_a == '0) || (src_b == '0);
`else
  assign early = 1'b0;
`endif
  assign div0 = div_q && (opnd_q == '0);
  assign quo = neg_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem = rneg_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];
  assign res = div0 ? {a_q, DIV0_QUOTIENT[W-1:0]} : zero_q ? '0 : div_q ? {rem, quo} : (neg_q ? -acc_q : acc_q);
  muldiv_step #(.W(W)) u_step (
    .is_div_i(div_q),
    .acc_i   (acc_q),
    .opnd_i  (opnd_q),
    .acc_o   (step_acc)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      opnd_q  <= '0;
      a_q     <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      zero_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else if (state_q != IDLE && flush) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        IDLE: if (start && !flush) begin
          state_q <= RUN;
          cnt_q   <= '0;
          acc_q   <= {{W{1'b0}}, is_div ? mag_a : mag_b};
          opnd_q  <= is_div ? mag_b : mag_a;
          a_q     <= src_a;
          div_q   <= is_div;
          neg_q   <= sgn && (src_a[W-1] ^ src_b[W-1]);
          rneg_q  <= sgn && src_a[W-1];
          zero_q  <= early;
        end
        RUN: if (zero_q) begin
          state_q      <= DONE;
          {hi_q, lo_q} <= res;
        end else begin
          acc_q <= step_acc;
          cnt_q <= (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
          if (cnt_q == CNT_W'(W - 1)) state_q <= FIXUP;
        end
        FIXUP: begin
          state_q      <= DONE;
          cnt_q        <= '0;
          {hi_q, lo_q} <= res;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign busy = state_q != IDLE;
  assign hilo_write_en = (state_q == DONE) && !flush;
  assign hi_out = hi_q;
  assign lo_out = lo_q;
endmodule

// File: tb/tb_muldiv_hilo_unit.sv
// tb_muldiv_hilo_unit: scoreboard bench for muldiv_hilo_unit; honours MULDIV_EARLY_ZERO_EN
module tb_muldiv_hilo_unit;
  localparam int W = 32;
`ifdef MULDIV_EARLY_ZERO_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif
  typedef struct {
    logic [63:0] res;
    int          at;
  } exp_t;
  logic clk = 1'b0, rst = 1'b1, start = 1'b0, flush = 1'b0;
  logic [1:0] op = 2'b00;
  logic [W-1:0] src_a = '0, src_b = '0;
  logic busy, hilo_write_en;
  logic [W-1:0] hi_out, lo_out;
  exp_t q_exp[$];
  int vectors = 0, miscompares = 0, ncyc = 0, pulses = 0;
  logic [63:0] last_res = '0;
  muldiv_hilo_unit #(.WORD_SIZE(W), .CNT_W(6)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
    .flush(flush), .busy(busy), .hi_out(hi_out), .lo_out(lo_out), .hilo_write_en(hilo_write_en)
  );
  always #5 clk = ~clk;
  function automatic logic [63:0] model(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int sa = $signed(a);
    int sb = $signed(b);
    int q, r;
    longint p;
    if (o == 2'b00) begin
      p = longint'(sa) * longint'(sb);
      return p;
    end
    if (o == 2'b01) return {32'b0, a} * {32'b0, b};
    if (b == '0) return {a, 32'hFFFF_FFFF};
    if (o == 2'b11) return {a % b, a / b};
    if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    q = sa / sb;
    r = sa % sb;
    return {r, q};
  endfunction
  function automatic int lat(input logic [W-1:0] a, input logic [W-1:0] b);
    return (EARLY && (a == '0 || b == '0)) ? 2 : W + 2;
  endfunction
  function automatic logic [W-1:0] rnd();
    case ($urandom_range(0, 6))
      0: return '0;
      1: return 32'h8000_0000;
      2: return '1;
      3: return W'($urandom_range(0, 20));
      4: return -W'($urandom_range(1, 20));
      default: return $urandom;
    endcase
  endfunction
  always @(negedge clk) begin
    exp_t e;
    ncyc = ncyc + 1;
    if (hilo_write_en) begin
      pulses = pulses + 1;
      vectors = vectors + 1;
      if (q_exp.size() == 0) begin
        miscompares = miscompares + 1;
        $display("FAIL pulse: unexpected write_en at cycle %0d, expected none", ncyc);
      end else begin
        e = q_exp.pop_front();
        if ({hi_out, lo_out} !== e.res || ncyc != e.at) begin
          miscompares = miscompares + 1;
          $display("FAIL result: hi/lo=%h at cycle %0d, expected %h at cycle %0d", {hi_out, lo_out}, ncyc, e.res, e.at);
        end
      end
    end else if (q_exp.size() != 0 && ncyc > q_exp[0].at) begin
      e = q_exp.pop_front();
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL missing_pulse: no write_en by cycle %0d, expected %h at cycle %0d", ncyc, e.res, e.at);
    end
  end
  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    vectors = vectors + 1;
    if (act !== exp) begin
      miscompares = miscompares + 1;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask
  task automatic step_to(input int n);
    while (ncyc < n) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b, input bit push, output int m);
    @(negedge clk);
    #1;
    m = ncyc;
    start = 1'b1;
    op = o;
    src_a = a;
    src_b = b;
    if (push) begin
      last_res = model(o, a, b);
      q_exp.push_back('{last_res, m + lat(a, b)});
    end
    @(negedge clk);
    #1;
    start = 1'b0;
  endtask
  task automatic wait_idle();
    int n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (busy) begin
      vectors = vectors + 1;
      miscompares = miscompares + 1;
      $display("FAIL timeout: busy=%b after %0d cycles, expected 0", busy, n);
    end
    repeat (2) begin
      @(negedge clk);
      #1;
    end
  endtask
  task automatic run(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int m;
    issue(o, a, b, 1'b1, m);
    wait_idle();
  endtask
  initial begin
    int m, p0;
    repeat (3) @(negedge clk);
    #1;
    chk("reset_busy", W'(busy), '0);
    chk("reset_we", W'(hilo_write_en), '0);
    chk("reset_hi", hi_out, '0);
    chk("reset_lo", lo_out, '0);
    rst = 1'b0;
    run(2'b00, 32'hFFFF_FFFD, 32'd5);
    run(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run(2'b11, 32'd100, 32'd7);
    run(2'b10, -32'd7, 32'd2);
    run(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
    run(2'b11, 32'h1234_5678, 32'd0);
    run(2'b10, 32'h8765_4321, 32'd0);
    run(2'b10, 32'd0, 32'd9);
    run(2'b00, 32'd0, 32'hFFFF_FFFF);
    chk("hold_hi", hi_out, last_res[63:32]);
    chk("hold_lo", lo_out, last_res[31:0]);
    for (int i = 0; i < 40; i++) run(2'($urandom_range(0, 3)), rnd(), rnd());
    issue(2'b01, 32'h0001_0003, 32'h0000_0100, 1'b1, m);
    step_to(m + 5);
    start = 1'b1;
    op = 2'b11;
    src_a = 32'hDEAD_BEEF;
    src_b = 32'd3;
    step_to(m + 6);
    start = 1'b0;
    wait_idle();
    p0 = pulses;
    issue(2'b10, 32'h7777_0000, 32'd13, 1'b0, m);
    step_to(m + 10);
    flush = 1'b1;
    step_to(m + 11);
    flush = 1'b0;
    step_to(m + 12);
    chk("flush_busy", W'(busy), '0);
    step_to(m + 50);
    chk("flush_pulses", pulses, p0);
    chk("flush_hi", hi_out, last_res[63:32]);
    chk("flush_lo", lo_out, last_res[31:0]);
    issue(2'b10, 32'h0BAD_CAFE, -32'd77, 1'b0, m);
    step_to(m + 20);
    rst = 1'b1;
    step_to(m + 21);
    rst = 1'b0;
    last_res = '0;
    chk("rst_busy", W'(busy), '0);
    chk("rst_hi", hi_out, '0);
    chk("rst_lo", lo_out, '0);
    step_to(m + 50);
    chk("rst_pulses", pulses, p0);
    run(2'b10, -32'd1000, 32'd33);
    chk("queue_drained", q_exp.size(), '0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
